// File: rtl/datamemory_be_pkg.sv
// rtl/datamemory_be_pkg.sv - shared types, widths and parameter legality check for datamemory_be
package datamemory_be_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 16;
   localparam int BE_W       = DATA_W_DEF / 8;

   function automatic bit params_ok(input int data_w, input int addr_w,
                                    input longint depth, input longint clear_words);
      return (data_w > 0) && (data_w % 8 == 0) && (addr_w > 0) && (addr_w < 63) &&
             (depth >= 1) && (depth <= (longint'(1) << addr_w)) &&
             (clear_words >= 0) && (clear_words <= depth);
   endfunction

endpackage

// File: rtl/datamemory_be_if.sv
// rtl/datamemory_be_if.sv - request/response bundle between load/store unit and data memory
interface datamemory_be_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/datamemory_be_array.sv
// rtl/datamemory_be_array.sv - plain synchronous array, byte-enable write port and registered read port
module datamemory_be_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = 10
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic                re_i,
   input  logic [AW-1:0]       addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] be_i,
   output logic [DATA_W-1:0]   rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < DATA_W / 8; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/datamemory_be.sv
// rtl/datamemory_be.sv - byte-enable data memory with post-reset clear engine and one-cycle reads
module datamemory_be
   import datamemory_be_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 2 ** ADDR_W,
   parameter int CLEAR_WORDS = 33
) (
   input  logic           clk,
   input  logic           reset,
   datamemory_be_if.slave bus
);
   localparam int BeW = DATA_W / 8;
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam state_e RstState = (CLEAR_WORDS == 0) ? RUN : CLEAR;
   localparam logic [ADDR_W-1:0] LastClr = ADDR_W'((CLEAR_WORDS > 0) ? CLEAR_WORDS - 1 : 0);
   localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);

   if (!params_ok(DATA_W, ADDR_W, longint'(DEPTH), longint'(CLEAR_WORDS))) begin : g_bad_params
      $error("datamemory_be: illegal DATA_W/ADDR_W/DEPTH/CLEAR_WORDS combination");
   end

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                rsp_valid_q, rsp_err_q;
   logic [DATA_W-1:0]   rsp_hold_q;

   logic                in_range, accept, rd_accept;
   logic                arr_we, arr_re;
   logic [AW-1:0]       arr_addr;
   logic [DATA_W-1:0]   arr_wdata, arr_rdata;
   logic [BeW-1:0]      arr_be;

   assign in_range  = {1'b0, bus.req_addr} < DepthW;
   assign accept    = reset && (state_q == RUN) && bus.req_valid;
   assign rd_accept = accept && !bus.req_write;

   // Array enables are gated by reset so asserting reset never disturbs stored words.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_addr  = bus.req_addr[AW-1:0];
      arr_wdata = bus.req_wdata;
      arr_be    = bus.req_be;
      case (state_q)
         CLEAR: begin
            arr_we    = reset;
            arr_addr  = cnt_q[AW-1:0];
            arr_wdata = '0;
            arr_be    = '1;
            cnt_d     = cnt_q + ADDR_W'(1);
            if (cnt_q == LastClr) begin
               state_d = RUN;
            end
         end
         RUN: begin
            arr_we = accept && bus.req_write && in_range;
            arr_re = rd_accept && in_range;
         end
         default: state_d = RstState;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= RstState;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rd_accept;
         if (rd_accept) begin
            rsp_err_q <= !in_range;
         end
         if (rsp_valid_q) begin
            rsp_hold_q <= bus.rsp_rdata;
         end
      end
   end

   datamemory_be_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (arr_addr),
      .wdata_i (arr_wdata),
      .be_i    (arr_be),
      .rdata_o (arr_rdata)
   );

   // Read data is live from the array on the response cycle, then held.
   assign bus.rsp_rdata = rsp_valid_q ? (rsp_err_q ? '0 : arr_rdata) : rsp_hold_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.req_ready = (state_q == RUN);
   assign bus.busy      = (state_q == CLEAR);
endmodule

// File: tb/tb_datamemory_be.sv
// tb/tb_datamemory_be.sv - randomized self-checking bench for datamemory_be against a behavioural model
module tb_datamemory_be;
   localparam int DW    = 32;
   localparam int AWID  = 16;
   localparam int DEPTH = 1024;
   localparam int CW    = 33;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   datamemory_be_if #(.DATA_W(DW), .ADDR_W(AWID)) bus ();

   datamemory_be #(
      .DATA_W      (DW),
      .ADDR_W      (AWID),
      .DEPTH       (DEPTH),
      .CLEAR_WORDS (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural model: word array plus "clear words still to go".
   logic [DW-1:0] mdl [DEPTH];
   int            clr_left = CW;
   bit            m_init = 1'b0;
   logic          m_valid = 1'b0;
   logic          m_err = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   always @(posedge clk) begin
      if (!reset) begin
         m_init   = 1'b1;
         clr_left = CW;
         m_valid  = 1'b0;
         m_err    = 1'b0;
         m_rdata  = '0;
      end else if (clr_left > 0) begin
         mdl[CW - clr_left] = '0;
         clr_left = clr_left - 1;
         m_valid  = 1'b0;
      end else begin
         m_valid = 1'b0;
         if (bus.req_valid) begin
            if (bus.req_write) begin
               if (int'(bus.req_addr) < DEPTH) begin
                  for (int i = 0; i < DW / 8; i++) begin
                     if (bus.req_be[i]) mdl[int'(bus.req_addr)][8*i +: 8] = bus.req_wdata[8*i +: 8];
                  end
               end
            end else begin
               m_valid = 1'b1;
               if (int'(bus.req_addr) < DEPTH) begin
                  m_rdata = mdl[int'(bus.req_addr)];
                  m_err   = 1'b0;
               end else begin
                  m_rdata = '0;
                  m_err   = 1'b1;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_init) begin
         check("busy", DW'(bus.busy), DW'(clr_left != 0));
         check("req_ready", DW'(bus.req_ready), DW'(clr_left == 0));
         check("rsp_valid", DW'(bus.rsp_valid), DW'(m_valid));
         check("rsp_err", DW'(bus.rsp_err), DW'(m_err));
         check("rsp_rdata", bus.rsp_rdata, m_rdata);
      end
   end

   task automatic idle();
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
   endtask

   // Called at a negedge; returns at the negedge after acceptance, where a read response is visible.
   task automatic issue(input bit w, input int addr, input logic [DW-1:0] d, input logic [3:0] be);
      int n = 0;
      while (!bus.req_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got 0 want 1");
      end
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = AWID'(addr);
      bus.req_wdata = d;
      bus.req_be    = be;
      @(negedge clk);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   int n;
   int a;

   initial begin
      idle();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      count_busy(n);
      check("clear_len_first", DW'(n), 32'd33);

      issue(1, 5, 32'hDEADBEEF, 4'hF);
      issue(0, 5, '0, 4'h0);
      check("preload_5", bus.rsp_rdata, 32'hDEADBEEF);
      idle();

      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      count_busy(n);
      check("clear_len_second", DW'(n), 32'd33);
      issue(0, 5, '0, 4'h0);
      check("cleared_5", bus.rsp_rdata, 32'h0);
      check("cleared_5_err", DW'(bus.rsp_err), 32'h0);
      idle();

      for (int i = CW; i < 64; i++) issue(1, i, $urandom, 4'hF);
      issue(1, 976, 32'h0BADF00D, 4'hF);

      issue(1, 100, 32'h11223344, 4'hF);
      issue(1, 100, 32'hAABBCCDD, 4'h5);
      issue(0, 100, '0, 4'h0);
      check("merge_100", bus.rsp_rdata, 32'h11BB33DD);

      issue(1, 1, 32'hA, 4'hF);
      issue(1, 2, 32'hB, 4'hF);
      issue(1, 3, 32'hC, 4'hF);
      issue(0, 1, '0, 4'h0);
      check("b2b_v1", DW'(bus.rsp_valid), 32'h1);
      check("b2b_d1", bus.rsp_rdata, 32'hA);
      issue(0, 2, '0, 4'h0);
      check("b2b_v2", DW'(bus.rsp_valid), 32'h1);
      check("b2b_d2", bus.rsp_rdata, 32'hB);
      issue(0, 3, '0, 4'h0);
      check("b2b_v3", DW'(bus.rsp_valid), 32'h1);
      check("b2b_d3", bus.rsp_rdata, 32'hC);

      issue(1, 2000, 32'hFFFFFFFF, 4'hF);
      issue(0, 2000, '0, 4'h0);
      check("oor_valid", DW'(bus.rsp_valid), 32'h1);
      check("oor_err", DW'(bus.rsp_err), 32'h1);
      check("oor_data", bus.rsp_rdata, 32'h0);
      issue(0, 0, '0, 4'h0);
      check("after_oor_err", DW'(bus.rsp_err), 32'h0);
      issue(0, 976, '0, 4'h0);
      check("no_alias_976", bus.rsp_rdata, 32'h0BADF00D);
      idle();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            idle();
            @(negedge clk);
         end else begin
            case ($urandom_range(9, 0))
               0:       a = 100;
               1:       a = 976;
               2:       a = $urandom_range(65535, 1024);
               default: a = $urandom_range(63, 0);
            endcase
            issue($urandom_range(1, 0) == 1, a, $urandom, 4'($urandom));
         end
      end
      idle();
      @(negedge clk);

      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = AWID'(5);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midclear_busy", DW'(bus.busy), 32'h1);
      reset = 1'b1;
      count_busy(n);
      check("clear_len_restart", DW'(n), 32'd33);
      @(negedge clk);
      check("held_req_valid", DW'(bus.rsp_valid), 32'h1);
      check("held_req_data", bus.rsp_rdata, 32'h0);
      idle();

      issue(0, 100, '0, 4'h0);
      idle();
      reset = 1'b0;
      @(negedge clk);
      check("cancel_valid", DW'(bus.rsp_valid), 32'h0);
      check("cancel_data", bus.rsp_rdata, 32'h0);
      check("cancel_err", DW'(bus.rsp_err), 32'h0);
      reset = 1'b1;
      count_busy(n);
      check("clear_len_final", DW'(n), 32'd33);
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
